// File: rtl/instr_decode_stage.sv
// Instruction decode stage: splits a 32-bit instruction into register/immediate
// fields and operand-select controls, buffered by an output register plus one skid slot.
module instr_decode_stage (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_ir_in,
  input  logic        i_ir_valid,
  output logic        o_ir_ready,
  input  logic        i_stall,
  input  logic        i_flush,
  output logic        o_out_valid,
  output logic [6:0]  o_opcode,
  output logic [4:0]  o_dr,
  output logic [4:0]  o_sa,
  output logic [4:0]  o_sb,
  output logic [14:0] o_im,
  output logic        o_mb,
  output logic        o_cs
);

  // state   | meaning
  // S_EMPTY | output and skid registers both invalid
  // S_FULL  | output register valid, skid invalid
  // S_SKID  | output and skid registers both valid, input blocked
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FULL  = 2'd1,
    S_SKID  = 2'd2
  } t_state;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  dr;
    logic [4:0]  sa;
    logic [4:0]  sb;
    logic [14:0] im;
    logic        mb;
    logic        cs;
  } t_dec;

  function automatic t_dec f_decode(input logic [31:0] ir);
    t_dec d;
    d.opcode = ir[31:25];
    d.dr     = ir[24:20];
    d.sa     = ir[19:15];
    d.sb     = ir[14:10];
    d.im     = ir[14:0];
    d.mb     = ir[31];
    d.cs     = ir[31] && !ir[25];
    return d;
  endfunction

  t_state r_state;
  t_state w_state_nxt;
  t_dec   r_or;
  t_dec   r_sk;
  t_dec   w_dec;
  logic   r_or_valid;
  logic   w_xfer;
  logic   w_accept;
  logic   w_ld_or;
  logic   w_or_from_sk;
  logic   w_ld_sk;

  assign w_dec      = f_decode(i_ir_in);
  assign o_ir_ready = (r_state != S_SKID);
  assign w_xfer     = i_ir_valid && o_ir_ready;
  assign w_accept   = r_or_valid && !i_stall;

  always_comb begin
    w_state_nxt  = r_state;
    w_ld_or      = 1'b0;
    w_or_from_sk = 1'b0;
    w_ld_sk      = 1'b0;
    if (i_flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_xfer) begin
            w_state_nxt = S_FULL;
            w_ld_or     = 1'b1;
          end
        end
        S_FULL: begin
          if (w_xfer && w_accept) begin
            w_ld_or = 1'b1;
          end else if (w_xfer) begin
            w_state_nxt = S_SKID;
            w_ld_sk     = 1'b1;
          end else if (w_accept) begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_SKID: begin
          if (w_accept) begin
            w_state_nxt  = S_FULL;
            w_or_from_sk = 1'b1;
          end
        end
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= S_EMPTY;
      r_or_valid <= 1'b0;
      r_or       <= '0;
      r_sk       <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_or_valid <= (w_state_nxt != S_EMPTY);
      if (w_ld_or)
        r_or <= w_dec;
      else if (w_or_from_sk)
        r_or <= r_sk;
      if (w_ld_sk)
        r_sk <= w_dec;
    end
  end

  assign o_out_valid = r_or_valid;
  assign o_opcode    = r_or.opcode;
  assign o_dr        = r_or.dr;
  assign o_sa        = r_or.sa;
  assign o_sb        = r_or.sb;
  assign o_im        = r_or.im;
  assign o_mb        = r_or.mb;
  assign o_cs        = r_or.cs;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage: decode values, skid/stall ordering,
// streaming throughput, flush and mid-operation reset.
module tb_instr_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ir_in;
  logic        ir_valid;
  logic        ir_ready;
  logic        stall;
  logic        flush;
  logic        out_valid;
  logic [6:0]  opcode;
  logic [4:0]  dr;
  logic [4:0]  sa;
  logic [4:0]  sb;
  logic [14:0] im;
  logic        mb;
  logic        cs;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_decode_stage dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_ir_in     (ir_in),
    .i_ir_valid  (ir_valid),
    .o_ir_ready  (ir_ready),
    .i_stall     (stall),
    .i_flush     (flush),
    .o_out_valid (out_valid),
    .o_opcode    (opcode),
    .o_dr        (dr),
    .o_sa        (sa),
    .o_sb        (sb),
    .o_im        (im),
    .o_mb        (mb),
    .o_cs        (cs)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ir_in = 32'hFFFF_FFFF; ir_valid = 1'b1; stall = 1'b0; flush = 1'b0;
    tick(); tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    total++; if ({opcode, dr, sa, sb, im, mb, cs} !== 39'd0) begin bad++; $display("FAIL reset_fields got=%h exp=0", {opcode, dr, sa, sb, im, mb, cs}); end
    ir_valid = 1'b0; ir_in = 32'd0;
    rst_n = 1'b1;
    tick();
    total++; if (ir_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", ir_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_idle_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_decode();
    ir_in = 32'h8430_C018; ir_valid = 1'b1;
    tick();
    ir_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL dec0_valid got=%b exp=1", out_valid); end
    total++; if (opcode !== 7'h42) begin bad++; $display("FAIL dec0_opcode got=%h exp=42", opcode); end
    total++; if (dr !== 5'd3) begin bad++; $display("FAIL dec0_dr got=%0d exp=3", dr); end
    total++; if (sa !== 5'd1) begin bad++; $display("FAIL dec0_sa got=%0d exp=1", sa); end
    total++; if (sb !== 5'd16) begin bad++; $display("FAIL dec0_sb got=%0d exp=16", sb); end
    total++; if (im !== 15'h4018) begin bad++; $display("FAIL dec0_im got=%h exp=4018", im); end
    total++; if (mb !== 1'b1 || cs !== 1'b1) begin bad++; $display("FAIL dec0_mbcs got=%b%b exp=11", mb, cs); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL dec0_drain got=%b exp=0", out_valid); end
    ir_in = 32'h0C30_C018; ir_valid = 1'b1;
    tick();
    total++; if (opcode !== 7'h06 || im !== 15'h4018) begin bad++; $display("FAIL dec1_fields got=%h/%h exp=06/4018", opcode, im); end
    total++; if (mb !== 1'b0 || cs !== 1'b0) begin bad++; $display("FAIL dec1_mbcs got=%b%b exp=00", mb, cs); end
    ir_in = 32'h8230_C018;
    tick();
    ir_valid = 1'b0;
    total++; if (opcode !== 7'h41 || out_valid !== 1'b1) begin bad++; $display("FAIL dec2_op got=%h v=%b exp=41 v=1", opcode, out_valid); end
    total++; if (mb !== 1'b1 || cs !== 1'b0) begin bad++; $display("FAIL dec2_mbcs got=%b%b exp=10", mb, cs); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL dec2_drain got=%b exp=0", out_valid); end
  endtask

  // A: op 7F im 0421, B: op 40 im 7FFF, C: op 05 im 5A5A
  task automatic test_stall_skid();
    stall = 1'b1;
    ir_in = 32'hFE1F_8421; ir_valid = 1'b1;
    tick();
    total++; if (ir_ready !== 1'b1 || opcode !== 7'h7F) begin bad++; $display("FAIL skid_a_load rdy=%b op=%h exp rdy=1 op=7f", ir_ready, opcode); end
    ir_in = 32'h8000_7FFF;
    tick();
    total++; if (ir_ready !== 1'b0) begin bad++; $display("FAIL skid_ready got=%b exp=0", ir_ready); end
    ir_in = 32'h0A5A_5A5A;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (out_valid !== 1'b1 || opcode !== 7'h7F || im !== 15'h0421 || ir_ready !== 1'b0) begin
        bad++; $display("FAIL skid_hold%0d v=%b op=%h im=%h rdy=%b exp v=1 op=7f im=0421 rdy=0", k, out_valid, opcode, im, ir_ready);
      end
    end
    stall = 1'b0;
    tick();
    total++; if (out_valid !== 1'b1 || opcode !== 7'h40 || im !== 15'h7FFF) begin bad++; $display("FAIL skid_b v=%b op=%h im=%h exp v=1 op=40 im=7fff", out_valid, opcode, im); end
    total++; if (mb !== 1'b1 || cs !== 1'b1 || ir_ready !== 1'b1) begin bad++; $display("FAIL skid_b_ctl mb=%b cs=%b rdy=%b exp 1 1 1", mb, cs, ir_ready); end
    tick();
    ir_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || opcode !== 7'h05 || im !== 15'h5A5A) begin bad++; $display("FAIL skid_c v=%b op=%h im=%h exp v=1 op=05 im=5a5a", out_valid, opcode, im); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL skid_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_ir;
    for (int k = 0; k <= 8; k++) begin
      if (k < 8) begin
        exp_ir   = 32'h0123_4567 + 32'h1357_9BDF * k;
        ir_in    = exp_ir;
        ir_valid = 1'b1;
        total++; if (ir_ready !== 1'b1) begin bad++; $display("FAIL stream_ready%0d got=%b exp=1", k, ir_ready); end
      end else begin
        ir_valid = 1'b0;
      end
      tick();
      if (k < 8) begin
        total++; if (out_valid !== 1'b1 || opcode !== exp_ir[31:25] || dr !== exp_ir[24:20] ||
                     sa !== exp_ir[19:15] || im !== exp_ir[14:0] ||
                     mb !== exp_ir[31] || cs !== (exp_ir[31] & ~exp_ir[25])) begin
          bad++; $display("FAIL stream_out%0d v=%b op=%h dr=%h sa=%h im=%h mb=%b cs=%b exp_ir=%h", k, out_valid, opcode, dr, sa, im, mb, cs, exp_ir);
        end
      end else begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain got=%b exp=0", out_valid); end
      end
    end
  endtask

  task automatic test_flush();
    stall = 1'b1;
    ir_in = 32'h8430_C018; ir_valid = 1'b1;
    tick();
    ir_in = 32'hFE1F_8421;
    tick();
    total++; if (ir_ready !== 1'b0) begin bad++; $display("FAIL flush_pre_skid rdy=%b exp=0", ir_ready); end
    flush = 1'b1; ir_in = 32'h0A5A_5A5A;
    tick();
    flush = 1'b0; ir_valid = 1'b0;
    total++; if (out_valid !== 1'b0 || ir_ready !== 1'b1) begin bad++; $display("FAIL flush_state v=%b rdy=%b exp v=0 rdy=1", out_valid, ir_ready); end
    total++; if (opcode !== 7'h42 || im !== 15'h4018) begin bad++; $display("FAIL flush_retain op=%h im=%h exp op=42 im=4018", opcode, im); end
    stall = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_ghost%0d v=%b op=%h exp v=0", k, out_valid, opcode); end
    end
  endtask

  task automatic test_reset_mid();
    stall = 1'b1;
    ir_in = 32'h8430_C018; ir_valid = 1'b1;
    tick();
    ir_valid = 1'b0;
    rst_n = 1'b0; flush = 1'b0;
    tick();
    total++; if (out_valid !== 1'b0 || ir_ready !== 1'b1) begin bad++; $display("FAIL rst_full v=%b rdy=%b exp v=0 rdy=1", out_valid, ir_ready); end
    total++; if ({opcode, dr, sa, sb, im, mb, cs} !== 39'd0) begin bad++; $display("FAIL rst_full_fields got=%h exp=0", {opcode, dr, sa, sb, im, mb, cs}); end
    rst_n = 1'b1;
    ir_valid = 1'b1; ir_in = 32'hFE1F_8421;
    tick();
    ir_in = 32'h8000_7FFF;
    tick();
    ir_valid = 1'b0;
    rst_n = 1'b0; flush = 1'b1; stall = 1'b0;
    tick();
    rst_n = 1'b1; flush = 1'b0;
    total++; if (out_valid !== 1'b0 || ir_ready !== 1'b1) begin bad++; $display("FAIL rst_skid v=%b rdy=%b exp v=0 rdy=1", out_valid, ir_ready); end
    ir_valid = 1'b1; ir_in = 32'h0A5A_5A5A;
    tick();
    ir_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || opcode !== 7'h05) begin bad++; $display("FAIL rst_after v=%b op=%h exp v=1 op=05", out_valid, opcode); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_after_drain v=%b op=%h exp v=0", out_valid, opcode); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_stall_skid();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_decode_stage.md
INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

Interface
REQ-001 CLK  input  1  single clock; all state updates on rising edge.
REQ-002 RST_N  input  1  reset, synchronous, active-low.
REQ-003 IR_IN  input  32  instruction word from fetch.
REQ-004 IR_VALID  input  1  IR_IN holds a valid instruction this cycle.
REQ-005 IR_READY  output  1  stage can accept; transfer when IR_VALID && IR_READY.
REQ-006 STALL  input  1  downstream not ready; output held while STALL=1.
REQ-007 FLUSH  input  1  discard all buffered instructions.
REQ-008 OUT_VALID  output  1  decoded fields below are valid.
REQ-009 OPCODE  output  7  IR[31:25].
REQ-010 DR  output  5  IR[24:20], destination register.
REQ-011 SA  output  5  IR[19:15], source A.
REQ-012 SB  output  5  IR[14:10], source B.
REQ-013 IM  output  15  IR[14:0], immediate to constant unit.
REQ-014 MB  output  1  1 = operand B from constant unit.
REQ-015 CS  output  1  1 = constant unit sign-extends IM; 0 = zero-extends.

Function
REQ-016 Decode rule: MB = OPCODE[6]; CS = OPCODE[6] && !OPCODE[0]; MB=0 forces CS=0.
REQ-017 All outputs except IR_READY are registered; fields and MB/CS are decoded when captured, not combinationally from IR_IN.
REQ-018 Storage: one output register (OR) plus one skid register (SK), each holding full decoded fields and a valid bit.
REQ-019 States: EMPTY (OR, SK invalid), FULL (OR valid, SK invalid), SKID (both valid).
REQ-020 IR_READY = 1 in EMPTY and FULL, 0 in SKID; combinational from state only, never from STALL.
REQ-021 Output accept: OUT_VALID && !STALL.
REQ-022 EMPTY: input transfer -> FULL, OR loaded; latency IR_VALID to OUT_VALID = 1 cycle.
REQ-023 FULL: transfer and accept -> FULL, OR reloaded; transfer without accept -> SKID, SK loaded; accept without transfer -> EMPTY; neither -> hold.
REQ-024 SKID: accept -> FULL, OR <= SK, SK invalidated; no accept -> hold; IR_VALID ignored.
REQ-025 Order preserved: instructions leave in arrival order, none duplicated or dropped.
REQ-026 OR fields stable while OUT_VALID && STALL.
REQ-027 FLUSH=1 -> next state EMPTY, OUT_VALID=0; any same-cycle input transfer discarded; FLUSH overrides STALL and IR_VALID.
REQ-028 Field registers keep prior values when invalid; consumers qualify with OUT_VALID.

Reset
REQ-029 RST_N=0 at a clock edge -> state EMPTY; OUT_VALID=0; OPCODE, DR, SA, SB, IM, MB, CS all 0; SK cleared.
REQ-030 IR_READY=1 in the first cycle after reset release.
REQ-031 Reset mid-operation (FULL or SKID) discards buffered instructions; reset has priority over FLUSH, STALL, IR_VALID.

Verification
REQ-032 Reset, then IR_IN=0x8430C018 with IR_VALID=1, STALL=0 for one cycle -> next cycle OUT_VALID=1, OPCODE=0x42, DR=3, SA=1, SB=16, IM=0x4018, MB=1, CS=1.
REQ-033 IR_IN=0x0C30C018 (OPCODE=0x06) -> MB=0, CS=0, IM=0x4018; IR_IN=0x8230C018 (OPCODE=0x41) -> MB=1, CS=0.
REQ-034 STALL=1 with back-to-back instructions A, B, C -> A held on outputs; B in skid; IR_READY=0 after B; C withheld by source; STALL=0 -> A, B, C emitted in order on consecutive accept cycles.
REQ-035 Continuous IR_VALID=1, STALL=0, 8 instructions -> 8 outputs on 8 consecutive cycles, IR_READY constant 1.
REQ-036 State SKID, FLUSH=1 with IR_VALID=1 -> next cycle OUT_VALID=0, IR_READY=1; flushed instructions and the same-cycle input never appear.
REQ-037 RST_N=0 while FULL with STALL=1 -> next cycle OUT_VALID=0, all fields 0, IR_READY=1.
